// File: rtl/multicycle_ctrl_if.sv
//------------------------------------------------------------------------------
// multicycle_ctrl_if : bundle between the multicycle control FSM and the datapath
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface multicycle_ctrl_if #(
   parameter int CTRL_W = 4,
   parameter int CNT_W  = 32
);
   logic [5:0]        opcode;
   logic [5:0]        funct;
   logic              zero;
   logic              ir_write;
   logic              i_or_d;
   logic              alu_src_a;
   logic [1:0]        alu_src_b;
   logic [CTRL_W-1:0] alu_ctrl;
   logic              reg_dst;
   logic              mem_to_reg;
   logic              reg_write;
   logic              mem_write;
   logic              branch;
   logic              pc_write;
   logic [1:0]        pc_src;
   logic              pc_en;
   logic              instr_done;
   logic              illegal;
   logic [CNT_W-1:0]  retired;

   modport master (
      input  opcode, funct, zero,
      output ir_write, i_or_d, alu_src_a, alu_src_b, alu_ctrl, reg_dst, mem_to_reg,
             reg_write, mem_write, branch, pc_write, pc_src, pc_en, instr_done,
             illegal, retired
   );

   modport slave (
      output opcode, funct, zero,
      input  ir_write, i_or_d, alu_src_a, alu_src_b, alu_ctrl, reg_dst, mem_to_reg,
             reg_write, mem_write, branch, pc_write, pc_src, pc_en, instr_done,
             illegal, retired
   );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
//------------------------------------------------------------------------------
// multicycle_ctrl : multicycle MIPS control sequencer with retire counter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_ctrl #(
   parameter int CTRL_W = 4,
   parameter int CNT_W  = 32
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   multicycle_ctrl_if.master  bus
);
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [CTRL_W-1:0] ALU_ADD = CTRL_W'(4'b0010);
   localparam logic [CTRL_W-1:0] ALU_SUB = CTRL_W'(4'b0110);
   localparam logic [CTRL_W-1:0] ALU_AND = CTRL_W'(4'b0000);
   localparam logic [CTRL_W-1:0] ALU_OR  = CTRL_W'(4'b0001);
   localparam logic [CTRL_W-1:0] ALU_SLT = CTRL_W'(4'b0111);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC    = 4'd6,
      S_ALUWB   = 4'd7,
      S_BEQ     = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11,
      S_ILLEGAL = 4'd12
   } state_t;

   typedef struct packed {
      logic              ir_write;
      logic              i_or_d;
      logic              alu_src_a;
      logic [1:0]        alu_src_b;
      logic [CTRL_W-1:0] alu_ctrl;
      logic              reg_dst;
      logic              mem_to_reg;
      logic              reg_write;
      logic              mem_write;
      logic              branch;
      logic              pc_write;
      logic [1:0]        pc_src;
      logic              instr_done;
   } ctrl_t;

   state_t           state_q, state_d;
   ctrl_t            ctrl_q, ctrl_d;
   logic             run_q;
   logic             illegal_q;
   logic [CNT_W-1:0] retired_q;
   logic             funct_ok;
   logic [CTRL_W-1:0] funct_alu;

   always_comb begin
      funct_ok  = 1'b1;
      funct_alu = ALU_ADD;
      case (bus.funct)
         FN_ADD:  funct_alu = ALU_ADD;
         FN_SUB:  funct_alu = ALU_SUB;
         FN_AND:  funct_alu = ALU_AND;
         FN_OR:   funct_alu = ALU_OR;
         FN_SLT:  funct_alu = ALU_SLT;
         default: funct_ok  = 1'b0;
      endcase
   end

   // run_q holds the first post-reset cycle in FETCH so its outputs are loaded before use.
   always_comb begin
      state_d = S_FETCH;
      if (run_q) begin
         case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
               case (bus.opcode)
                  OP_LW, OP_SW: state_d = S_MEMADR;
                  OP_RTYPE:     state_d = S_EXEC;
                  OP_BEQ:       state_d = S_BEQ;
                  OP_ADDI:      state_d = S_ADDIEX;
                  OP_J:         state_d = S_JUMP;
                  default:      state_d = S_ILLEGAL;
               endcase
            end
            S_MEMADR: state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = funct_ok ? S_ALUWB : S_ILLEGAL;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
         endcase
      end
   end

   // Outputs are decoded from the state being entered, so they are registered yet Moore.
   always_comb begin
      ctrl_d = '0;
      case (state_d)
         S_FETCH: begin
            ctrl_d.ir_write  = 1'b1;
            ctrl_d.pc_write  = 1'b1;
            ctrl_d.alu_src_b = 2'b01;
            ctrl_d.alu_ctrl  = ALU_ADD;
         end
         S_DECODE: begin
            ctrl_d.alu_src_b = 2'b11;
            ctrl_d.alu_ctrl  = ALU_ADD;
         end
         S_MEMADR, S_ADDIEX: begin
            ctrl_d.alu_src_a = 1'b1;
            ctrl_d.alu_src_b = 2'b10;
            ctrl_d.alu_ctrl  = ALU_ADD;
         end
         S_MEMRD: ctrl_d.i_or_d = 1'b1;
         S_MEMWB: begin
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.mem_to_reg = 1'b1;
            ctrl_d.instr_done = 1'b1;
         end
         S_MEMWR: begin
            ctrl_d.i_or_d     = 1'b1;
            ctrl_d.mem_write  = 1'b1;
            ctrl_d.instr_done = 1'b1;
         end
         S_EXEC: begin
            ctrl_d.alu_src_a = 1'b1;
            ctrl_d.alu_ctrl  = funct_alu;
         end
         S_ALUWB: begin
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.reg_dst    = 1'b1;
            ctrl_d.instr_done = 1'b1;
         end
         S_BEQ: begin
            ctrl_d.alu_src_a  = 1'b1;
            ctrl_d.alu_ctrl   = ALU_SUB;
            ctrl_d.branch     = 1'b1;
            ctrl_d.pc_src     = 2'b01;
            ctrl_d.instr_done = 1'b1;
         end
         S_ADDIWB: begin
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.instr_done = 1'b1;
         end
         S_JUMP: begin
            ctrl_d.pc_write   = 1'b1;
            ctrl_d.pc_src     = 2'b10;
            ctrl_d.instr_done = 1'b1;
         end
         default: ctrl_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         ctrl_q    <= '0;
         run_q     <= 1'b0;
         illegal_q <= 1'b0;
         retired_q <= '0;
      end else begin
         run_q   <= 1'b1;
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         if (state_d == S_ILLEGAL) begin
            illegal_q <= 1'b1;
         end
         if (ctrl_q.instr_done) begin
            retired_q <= retired_q + CNT_W'(1);
         end
      end
   end

   assign bus.ir_write   = ctrl_q.ir_write;
   assign bus.i_or_d     = ctrl_q.i_or_d;
   assign bus.alu_src_a  = ctrl_q.alu_src_a;
   assign bus.alu_src_b  = ctrl_q.alu_src_b;
   assign bus.alu_ctrl   = ctrl_q.alu_ctrl;
   assign bus.reg_dst    = ctrl_q.reg_dst;
   assign bus.mem_to_reg = ctrl_q.mem_to_reg;
   assign bus.reg_write  = ctrl_q.reg_write;
   assign bus.mem_write  = ctrl_q.mem_write;
   assign bus.branch     = ctrl_q.branch;
   assign bus.pc_write   = ctrl_q.pc_write;
   assign bus.pc_src     = ctrl_q.pc_src;
   assign bus.pc_en      = ctrl_q.pc_write | (ctrl_q.branch & bus.zero);
   assign bus.instr_done = ctrl_q.instr_done;
   assign bus.illegal    = illegal_q;
   assign bus.retired    = retired_q;

endmodule

`default_nettype wire
